// File: rtl/ysyx_lsu_store_axi.sv
// Store write master: takes one committed store from the store queue head,
// lane-aligns data/strobes onto the 32-bit bus, runs the AW/W/B handshakes
// and returns a completion pulse (with error code) so the head can retire.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a store; req_ready high (low for one cycle after done)
// SEND  | AW and W offered independently until both have handshaked
// RESP  | bready high, waiting for B; watchdog counts missing response
// FAIL  | misaligned/illegal-size store, reported without bus activity
module ysyx_lsu_store_axi #(
  parameter int XLEN      = 32,
  parameter int TIMEOUT_W = 10
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_data,
  input  logic [1:0]      req_size,
  output logic            done,
  output logic            err,
  output logic [1:0]      err_code,
  output logic            awvalid,
  input  logic            awready,
  output logic [XLEN-1:0] awaddr,
  output logic            wvalid,
  input  logic            wready,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      wstrb,
  input  logic            bvalid,
  output logic            bready,
  input  logic [1:0]      bresp
);

  typedef enum logic [1:0] {IDLE, SEND, RESP, FAIL} state_t;

  state_t                state;
  logic [TIMEOUT_W-1:0]  wd_cnt;
  logic [TIMEOUT_W-1:0]  wd_next;
  logic                  misaligned;
  logic [3:0]            strb_al;
  logic [XLEN-1:0]       data_al;
  logic                  aw_ok;
  logic                  w_ok;

  // Lane alignment and legality of the incoming request.
  always_comb begin
    misaligned = (req_size == 2'd3) ||
                 ((req_size == 2'd1) && req_addr[0]) ||
                 ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
    strb_al    = 4'b1111;
    data_al    = req_data;
    case (req_size)
      2'd0: begin
        strb_al = 4'b0001 << req_addr[1:0];
        data_al = {4{req_data[7:0]}};
      end
      2'd1: begin
        strb_al = 4'b0011 << req_addr[1:0];
        data_al = {2{req_data[15:0]}};
      end
      default: begin
        strb_al = 4'b1111;
        data_al = req_data;
      end
    endcase
  end

  // A channel counts as done once its valid has dropped or it handshakes now.
  always_comb begin
    aw_ok   = !awvalid || awready;
    w_ok    = !wvalid || wready;
    wd_next = wd_cnt + TIMEOUT_W'(1);
  end

  // Sequencer with registered outputs; done/err pulse for a single cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
      awvalid   <= 1'b0;
      awaddr    <= '0;
      wvalid    <= 1'b0;
      wdata     <= '0;
      wstrb     <= 4'b0000;
      bready    <= 1'b0;
      wd_cnt    <= '0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'd0;
      case (state)
        IDLE: begin
          if (!req_ready) begin
            req_ready <= 1'b1;
          end else if (req_valid) begin
            req_ready <= 1'b0;
            if (misaligned) begin
              state <= FAIL;
            end else begin
              state   <= SEND;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              awaddr  <= {req_addr[XLEN-1:2], 2'b00};
              wdata   <= data_al;
              wstrb   <= strb_al;
            end
          end
        end
        SEND: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            state  <= RESP;
            bready <= 1'b1;
            wd_cnt <= '0;
          end
        end
        RESP: begin
          if (bvalid) begin
            state  <= IDLE;
            bready <= 1'b0;
            done   <= 1'b1;
            if (bresp != 2'b00) begin
              err      <= 1'b1;
              err_code <= 2'd2;
            end
          end else if (wd_next == '1) begin
            state    <= IDLE;
            bready   <= 1'b0;
            wd_cnt   <= wd_next;
            done     <= 1'b1;
            err      <= 1'b1;
            err_code <= 2'd3;
          end else begin
            wd_cnt <= wd_next;
          end
        end
        FAIL: begin
          state    <= IDLE;
          done     <= 1'b1;
          err      <= 1'b1;
          err_code <= 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
